// File: rtl/instr_mem_block.sv
// Instruction memory: byte-addressed little-endian word store with a fixed
// multi-cycle read latency, single-word or aligned block reads, and a preload port.
module instr_mem_block #(
    parameter int ADDR_W       = 10,
    parameter int BLOCK_WORDS  = 4,
    parameter int READ_LATENCY = 4
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     READ,
    input  logic                     BLOCK,
    input  logic [ADDR_W-1:0]        ADDRESS,
    input  logic                     WRITE_EN,
    input  logic [ADDR_W-1:0]        WRITE_ADDR,
    input  logic [31:0]              WRITE_DATA,
    output logic                     BUSYWAIT,
    output logic [32*BLOCK_WORDS-1:0] READDATA,
    output logic                     VALID,
    output logic                     ERROR
);

    localparam int WORD_W = ADDR_W - 2;
    localparam int DEPTH  = 1 << WORD_W;
    localparam int BLK_W  = $clog2(BLOCK_WORDS);
    localparam int CNT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [31:0]       mem [DEPTH];
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [WORD_W-1:0] lat_word;
    logic              lat_block;
    logic              accept;
    logic              busy_n;
    logic              valid_n;
    logic              error_n;
    logic              mem_we;
    logic              rd_ok;
    logic              rd_bad;
    logic              wr_ok;
    logic              wr_bad;
    logic              cnt_zero;
    logic [32*BLOCK_WORDS-1:0] rd_data;

    assign rd_ok    = READ && (ADDRESS[1:0] == 2'b00);
    assign rd_bad   = READ && (ADDRESS[1:0] != 2'b00);
    assign wr_ok    = WRITE_EN && (WRITE_ADDR[1:0] == 2'b00);
    assign wr_bad   = WRITE_EN && (WRITE_ADDR[1:0] != 2'b00);
    assign cnt_zero = (cnt == '0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (rd_ok) state_n = S_WAIT;
            S_WAIT: if (cnt_zero) state_n = S_DONE;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        accept  = (state == S_IDLE) && rd_ok;
        busy_n  = (state_n == S_WAIT);
        valid_n = (state == S_WAIT) && cnt_zero;
        error_n = (state == S_IDLE) && (rd_bad || wr_bad);
        mem_we  = (state == S_IDLE) && wr_ok && !RESET;
        cnt_n   = cnt;
        if (accept) begin
            cnt_n = CNT_INIT;
        end else if ((state == S_WAIT) && !cnt_zero) begin
            cnt_n = cnt - CNT_W'(1);
        end
    end

    // Storage is sampled at the completion edge, so same-cycle preloads are visible.
    always_comb begin
        rd_data = '0;
        if (lat_block) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                rd_data[32*i +: 32] = mem[{lat_word[WORD_W-1:BLK_W], BLK_W'(i)}];
            end
        end else begin
            rd_data[31:0] = mem[lat_word];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            BUSYWAIT  <= 1'b0;
            VALID     <= 1'b0;
            ERROR     <= 1'b0;
            READDATA  <= '0;
            cnt       <= '0;
            lat_word  <= '0;
            lat_block <= 1'b0;
        end else begin
            BUSYWAIT <= busy_n;
            VALID    <= valid_n;
            ERROR    <= error_n;
            cnt      <= cnt_n;
            if (accept) begin
                lat_word  <= ADDRESS[ADDR_W-1:2];
                lat_block <= BLOCK;
            end
            if (valid_n) begin
                READDATA <= rd_data;
            end
        end
    end

    // Contents survive reset; only the program-load port changes them.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[WRITE_ADDR[ADDR_W-1:2]] <= WRITE_DATA;
        end
    end

endmodule

// File: tb/tb_instr_mem_block.sv
// Scoreboard bench for instr_mem_block: expected responses queued at request
// time, popped and compared by a monitor whenever VALID pulses.
module tb_instr_mem_block;

    logic         CLK;
    logic         RESET;
    logic         READ;
    logic         BLOCK;
    logic [9:0]   ADDRESS;
    logic         WRITE_EN;
    logic [9:0]   WRITE_ADDR;
    logic [31:0]  WRITE_DATA;
    logic         BUSYWAIT;
    logic [127:0] READDATA;
    logic         VALID;
    logic         ERROR;

    int checks = 0;
    int fails  = 0;
    int n_valid = 0;

    logic [127:0] sb [$];
    logic [31:0]  model [256];

    instr_mem_block dut (
        .CLK(CLK),
        .RESET(RESET),
        .READ(READ),
        .BLOCK(BLOCK),
        .ADDRESS(ADDRESS),
        .WRITE_EN(WRITE_EN),
        .WRITE_ADDR(WRITE_ADDR),
        .WRITE_DATA(WRITE_DATA),
        .BUSYWAIT(BUSYWAIT),
        .READDATA(READDATA),
        .VALID(VALID),
        .ERROR(ERROR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (VALID === 1'b1) begin
            logic [127:0] exp;
            n_valid++;
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid: VALID=1 with no request outstanding, READDATA=%h", READDATA);
            end else begin
                exp = sb.pop_front();
                if (READDATA !== exp) begin
                    fails++;
                    $display("FAIL sb_readdata: got %h expected %h", READDATA, exp);
                end
            end
        end
    end

    function automatic logic [127:0] exp_of(input logic [9:0] a, input logic b);
        logic [127:0] r;
        logic [7:0]   w;
        r = '0;
        w = a[9:2];
        if (b) begin
            for (int i = 0; i < 4; i++) begin
                r[32*i +: 32] = model[{w[7:2], 2'(i)}];
            end
        end else begin
            r[31:0] = model[w];
        end
        return r;
    endfunction

    task automatic do_write(input logic [9:0] a, input logic [31:0] d, input bit upd);
        @(negedge CLK);
        WRITE_EN   = 1'b1;
        WRITE_ADDR = a;
        WRITE_DATA = d;
        if (upd) model[a[9:2]] = d;
        @(negedge CLK);
        WRITE_EN = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] a, input logic b);
        bit got;
        got = 1'b0;
        @(negedge CLK);
        READ    = 1'b1;
        ADDRESS = a;
        BLOCK   = b;
        sb.push_back(exp_of(a, b));
        @(negedge CLK);
        READ = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (VALID === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        checks++;
        if (!got) begin
            fails++;
            $display("FAIL read_timeout: addr=%h no VALID within 20 cycles", a);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        checks += 4;
        if (BUSYWAIT !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", BUSYWAIT); end
        if (VALID !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", VALID); end
        if (ERROR !== 1'b0) begin fails++; $display("FAIL rst_error: got %b expected 0", ERROR); end
        if (READDATA !== 128'h0) begin fails++; $display("FAIL rst_data: got %h expected 0", READDATA); end
        RESET = 1'b0;
    endtask

    task automatic test_single;
        do_write(10'h000, 32'h08060012, 1'b1);
        @(negedge CLK);
        READ    = 1'b1;
        ADDRESS = 10'h000;
        BLOCK   = 1'b0;
        sb.push_back(exp_of(10'h000, 1'b0));
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            READ = 1'b0;
            checks++;
            if (BUSYWAIT !== 1'b1) begin
                fails++;
                $display("FAIL single_busy%0d: got %b expected 1", k, BUSYWAIT);
            end
        end
        @(negedge CLK);
        checks += 3;
        if (BUSYWAIT !== 1'b0) begin fails++; $display("FAIL single_busy_end: got %b expected 0", BUSYWAIT); end
        if (VALID !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", VALID); end
        if (READDATA[31:0] !== 32'h08060012) begin
            fails++;
            $display("FAIL single_data: got %h expected 08060012", READDATA[31:0]);
        end
        @(negedge CLK);
        checks++;
        if (VALID !== 1'b0) begin fails++; $display("FAIL single_pulse: got %b expected 0", VALID); end
    endtask

    task automatic test_block;
        do_write(10'h010, 32'h11, 1'b1);
        do_write(10'h014, 32'h22, 1'b1);
        do_write(10'h018, 32'h33, 1'b1);
        do_write(10'h01C, 32'h44, 1'b1);
        do_read(10'h018, 1'b1);
        checks++;
        if (READDATA !== 128'h00000044_00000033_00000022_00000011) begin
            fails++;
            $display("FAIL block_data: got %h expected 44/33/22/11", READDATA);
        end
    endtask

    task automatic test_misaligned;
        do_write(10'h020, 32'hCAFEF00D, 1'b1);
        @(negedge CLK);
        WRITE_EN   = 1'b1;
        WRITE_ADDR = 10'h021;
        WRITE_DATA = 32'h12345678;
        @(negedge CLK);
        WRITE_EN = 1'b0;
        checks++;
        if (ERROR !== 1'b1) begin fails++; $display("FAIL mis_wr_error: got %b expected 1", ERROR); end
        READ    = 1'b1;
        ADDRESS = 10'h002;
        BLOCK   = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            checks += 2;
            if (ERROR !== 1'b1) begin fails++; $display("FAIL mis_rd_error%0d: got %b expected 1", k, ERROR); end
            if (BUSYWAIT !== 1'b0) begin fails++; $display("FAIL mis_rd_busy%0d: got %b expected 0", k, BUSYWAIT); end
        end
        READ = 1'b0;
        @(negedge CLK);
        checks++;
        if (ERROR !== 1'b0) begin fails++; $display("FAIL mis_error_clear: got %b expected 0", ERROR); end
        do_read(10'h020, 1'b0);
        checks++;
        if (READDATA[31:0] !== 32'hCAFEF00D) begin
            fails++;
            $display("FAIL mis_storage: got %h expected cafef00d", READDATA[31:0]);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge CLK);
        READ    = 1'b1;
        ADDRESS = 10'h000;
        BLOCK   = 1'b0;
        @(negedge CLK);
        READ = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        checks += 3;
        if (BUSYWAIT !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b expected 0", BUSYWAIT); end
        if (VALID !== 1'b0) begin fails++; $display("FAIL mid_valid: got %b expected 0", VALID); end
        if (READDATA !== 128'h0) begin fails++; $display("FAIL mid_data: got %h expected 0", READDATA); end
        repeat (8) @(negedge CLK);
        do_read(10'h000, 1'b0);
        checks++;
        if (READDATA[31:0] !== 32'h08060012) begin
            fails++;
            $display("FAIL mid_reissue: got %h expected 08060012", READDATA[31:0]);
        end
    endtask

    task automatic test_back_to_back;
        int last;
        int nv;
        last = 0;
        nv   = 0;
        @(negedge CLK);
        READ    = 1'b1;
        ADDRESS = 10'h010;
        BLOCK   = 1'b0;
        repeat (3) sb.push_back(exp_of(10'h010, 1'b0));
        for (int t = 0; t < 60; t++) begin
            @(negedge CLK);
            if (t == 0) begin
                WRITE_EN   = 1'b1;
                WRITE_ADDR = 10'h010;
                WRITE_DATA = 32'hBAD0BAD0;
            end else if (t == 1) begin
                WRITE_EN = 1'b0;
            end
            if (VALID === 1'b1) begin
                if (nv > 0) begin
                    checks++;
                    if (t - last !== 6) begin
                        fails++;
                        $display("FAIL b2b_spacing: got %0d cycles expected 6", t - last);
                    end
                end
                last = t;
                nv++;
                if (nv == 3) break;
            end
        end
        READ = 1'b0;
        checks++;
        if (nv !== 3) begin fails++; $display("FAIL b2b_count: got %0d responses expected 3", nv); end
        checks++;
        if (READDATA[31:0] !== 32'h00000011) begin
            fails++;
            $display("FAIL b2b_wait_write: got %h expected 00000011", READDATA[31:0]);
        end
        @(negedge CLK);
    endtask

    task automatic test_top_of_mem;
        do_write(10'h3F0, 32'hA0A0A0A0, 1'b1);
        do_write(10'h3F4, 32'hB1B1B1B1, 1'b1);
        do_write(10'h3F8, 32'hC2C2C2C2, 1'b1);
        @(negedge CLK);
        READ       = 1'b1;
        ADDRESS    = 10'h3FC;
        BLOCK      = 1'b0;
        WRITE_EN   = 1'b1;
        WRITE_ADDR = 10'h3FC;
        WRITE_DATA = 32'hDEADBEEF;
        model[8'hFF] = 32'hDEADBEEF;
        sb.push_back(exp_of(10'h3FC, 1'b0));
        @(negedge CLK);
        READ     = 1'b0;
        WRITE_EN = 1'b0;
        repeat (4) @(negedge CLK);
        checks++;
        if (READDATA[31:0] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL simul_data: got %h expected deadbeef", READDATA[31:0]);
        end
        @(negedge CLK);
        do_read(10'h3F4, 1'b1);
        checks++;
        if (READDATA !== 128'hDEADBEEF_C2C2C2C2_B1B1B1B1_A0A0A0A0) begin
            fails++;
            $display("FAIL top_block: got %h expected deadbeef c2c2c2c2 b1b1b1b1 a0a0a0a0", READDATA);
        end
    endtask

    initial begin
        RESET      = 1'b1;
        READ       = 1'b0;
        BLOCK      = 1'b0;
        ADDRESS    = '0;
        WRITE_EN   = 1'b0;
        WRITE_ADDR = '0;
        WRITE_DATA = '0;
        test_reset();
        test_single();
        test_block();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        test_top_of_mem();
        repeat (3) @(negedge CLK);
        checks += 2;
        if (sb.size() !== 0) begin fails++; $display("FAIL sb_leftover: got %0d entries expected 0", sb.size()); end
        if (n_valid !== 9) begin fails++; $display("FAIL valid_total: got %0d pulses expected 9", n_valid); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
